// File: rtl/sweep_controller_if.sv
// Handshake bundle between the Bellman-Ford phase counter and the sweep controller.
interface sweep_controller_if #(
  parameter int IDX_W = 5
);
  logic             start;
  logic             rollover_phase_counter;
  logic             finish;
  logic             update_valid;
  logic             iteration_done;
  logic [IDX_W-1:0] node_index;
  logic [5:0]       sweep_updates;
  logic             busy;
  logic             converged;
  logic             neg_cycle;
  logic             done;

  modport slave (
    input  start, rollover_phase_counter, finish, update_valid,
    output iteration_done, node_index, sweep_updates, busy, converged, neg_cycle, done
  );

  modport master (
    output start, rollover_phase_counter, finish, update_valid,
    input  iteration_done, node_index, sweep_updates, busy, converged, neg_cycle, done
  );
endinterface

// File: rtl/sweep_controller.sv
// Steps node_index through each Bellman-Ford sweep and decides convergence / negative cycle at each wrap.
// iteration_done is registered (one edge after the wrap); busy/done decode straight from state.
module sweep_controller #(
  parameter int NODES = 32,
  parameter int IDX_W = 5
) (
  input  logic               clk,
  input  logic               rst_global,
  sweep_controller_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [IDX_W-1:0] LAST_NODE = IDX_W'(NODES - 1);

  logic [1:0]       state;
  logic             dirty;
  logic [5:0]       run_cnt;
  logic [IDX_W-1:0] node_q;
  logic [5:0]       sweep_q;
  logic             iter_q;
  logic             conv_q;
  logic             neg_q;

  logic             wrap;
  logic             eff_dirty;
  logic [5:0]       cnt_next;

  // An update landing in the wrap cycle still belongs to the sweep being closed.
  always_comb begin
    cnt_next = run_cnt;
    if (bus.update_valid && (run_cnt != 6'd63))
      cnt_next = run_cnt + 6'd1;
    wrap      = (state == RUN) && bus.rollover_phase_counter && (node_q == LAST_NODE);
    eff_dirty = dirty | bus.update_valid;
  end

  always_ff @(posedge clk or posedge rst_global) begin
    if (rst_global) begin
      state   <= IDLE;
      dirty   <= 1'b0;
      run_cnt <= 6'd0;
      node_q  <= '0;
      sweep_q <= 6'd0;
      iter_q  <= 1'b0;
      conv_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      iter_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state   <= RUN;
            node_q  <= '0;
            dirty   <= 1'b0;
            run_cnt <= 6'd0;
            conv_q  <= 1'b0;
            neg_q   <= 1'b0;
          end
        end
        RUN: begin
          if (wrap) begin
            node_q  <= '0;
            iter_q  <= 1'b1;
            sweep_q <= cnt_next;
            run_cnt <= 6'd0;
            dirty   <= 1'b0;
            if (!eff_dirty) begin
              conv_q <= 1'b1;
              state  <= DONE;
            end else if (bus.finish) begin
              neg_q <= 1'b1;
              state <= DONE;
            end
          end else begin
            if (bus.rollover_phase_counter)
              node_q <= node_q + 1'b1;
            if (bus.update_valid) begin
              dirty   <= 1'b1;
              run_cnt <= cnt_next;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.iteration_done = iter_q;
  assign bus.node_index     = node_q;
  assign bus.sweep_updates  = sweep_q;
  assign bus.converged      = conv_q;
  assign bus.neg_cycle      = neg_q;
  assign bus.busy           = (state == RUN);
  assign bus.done           = (state == DONE);

endmodule

// File: tb/tb_sweep_controller.sv
// Directed bench for sweep_controller (NODES=32): convergence, multi-sweep, negative cycle, wrap-cycle update, async reset, restart.
module tb_sweep_controller;

  logic clk;
  logic rst_global;
  int   checks;
  int   errors;
  int   pulses;

  sweep_controller_if #(.IDX_W(5)) sif ();

  sweep_controller #(.NODES(32), .IDX_W(5)) dut (
    .clk        (clk),
    .rst_global (rst_global),
    .bus        (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (sif.iteration_done === 1'b1) pulses++;
  endtask

  task automatic pulse_start();
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
  endtask

  // n rollover pulses, each preceded by one idle slot cycle
  task automatic roll(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      sif.rollover_phase_counter = 1'b1;
      tick();
      sif.rollover_phase_counter = 1'b0;
    end
  endtask

  // One full 32-node sweep starting at node 0.
  task automatic sweep(input int n_upd, input bit upd_wrap, input bit upd_all);
    for (int i = 0; i < 32; i++) begin
      sif.update_valid = upd_all || (i < n_upd);
      tick();
      sif.rollover_phase_counter = 1'b1;
      sif.update_valid = upd_all || (upd_wrap && (i == 31));
      tick();
      sif.rollover_phase_counter = 1'b0;
      sif.update_valid = 1'b0;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    pulses = 0;
    sif.start = 1'b0;
    sif.rollover_phase_counter = 1'b0;
    sif.finish = 1'b0;
    sif.update_valid = 1'b0;
    rst_global = 1'b1;
    #12;
    check_eq("rst_node_index", sif.node_index, 0);
    check_eq("rst_sweep_updates", sif.sweep_updates, 0);
    check_eq("rst_iteration_done", sif.iteration_done, 0);
    check_eq("rst_converged", sif.converged, 0);
    check_eq("rst_neg_cycle", sif.neg_cycle, 0);
    check_eq("rst_busy", sif.busy, 0);
    check_eq("rst_done", sif.done, 0);
    @(negedge clk);
    rst_global = 1'b0;

    // Single sweep with no updates converges on the first wrap
    pulse_start();
    check_eq("s1_busy", sif.busy, 1);
    check_eq("s1_node0", sif.node_index, 0);
    pulses = 0;
    roll(31);
    check_eq("s1_node31", sif.node_index, 31);
    check_eq("s1_no_pulse_early", pulses, 0);
    roll(1);
    check_eq("s1_iter_pulse", sif.iteration_done, 1);
    check_eq("s1_node_wrap", sif.node_index, 0);
    check_eq("s1_converged", sif.converged, 1);
    check_eq("s1_sweep_updates", sif.sweep_updates, 0);
    check_eq("s1_done", sif.done, 1);
    check_eq("s1_busy_low", sif.busy, 0);
    tick();
    check_eq("s1_iter_one_cycle", sif.iteration_done, 0);
    check_eq("s1_pulse_count", pulses, 1);

    // Inputs outside RUN are ignored; DONE holds its outputs
    sif.rollover_phase_counter = 1'b1;
    sif.update_valid = 1'b1;
    tick();
    tick();
    sif.rollover_phase_counter = 1'b0;
    sif.update_valid = 1'b0;
    check_eq("done_hold_node", sif.node_index, 0);
    check_eq("done_hold_conv", sif.converged, 1);
    check_eq("done_hold_done", sif.done, 1);

    // Restart from DONE: 3 updates then a clean sweep
    pulse_start();
    check_eq("s2_restart_conv_clr", sif.converged, 0);
    check_eq("s2_restart_busy", sif.busy, 1);
    pulses = 0;
    sweep(3, 1'b0, 1'b0);
    check_eq("s2_sweep1_updates", sif.sweep_updates, 3);
    check_eq("s2_sweep1_conv", sif.converged, 0);
    check_eq("s2_sweep1_busy", sif.busy, 1);
    sweep(0, 1'b0, 1'b0);
    check_eq("s2_sweep2_updates", sif.sweep_updates, 0);
    check_eq("s2_sweep2_conv", sif.converged, 1);
    check_eq("s2_pulses", pulses, 2);

    // Updates every cycle, finish raised before the 20th wrap
    pulse_start();
    pulses = 0;
    for (int s = 0; s < 19; s++) sweep(0, 1'b0, 1'b1);
    check_eq("s3_pulses19", pulses, 19);
    check_eq("s3_busy19", sif.busy, 1);
    check_eq("s3_saturated", sif.sweep_updates, 63);
    check_eq("s3_neg_early", sif.neg_cycle, 0);
    sif.finish = 1'b1;
    sweep(0, 1'b0, 1'b1);
    sif.finish = 1'b0;
    check_eq("s3_neg_cycle", sif.neg_cycle, 1);
    check_eq("s3_converged", sif.converged, 0);
    check_eq("s3_done", sif.done, 1);
    check_eq("s3_pulses20", pulses, 20);

    // Update only in the wrap cycle keeps the run alive
    pulse_start();
    check_eq("s4_neg_clr", sif.neg_cycle, 0);
    pulses = 0;
    sweep(0, 1'b1, 1'b0);
    check_eq("s4_sweep_updates", sif.sweep_updates, 1);
    check_eq("s4_conv", sif.converged, 0);
    check_eq("s4_busy", sif.busy, 1);
    check_eq("s4_pulse", pulses, 1);

    // start mid-RUN has no effect
    roll(5);
    pulse_start();
    check_eq("s5_start_ignored", sif.node_index, 5);
    check_eq("s5_still_busy", sif.busy, 1);

    // Async reset at node 17 aborts without iteration_done
    roll(12);
    check_eq("s6_node17", sif.node_index, 17);
    pulses = 0;
    @(posedge clk);
    #3;
    rst_global = 1'b1;
    #1;
    check_eq("s6_async_node", sif.node_index, 0);
    check_eq("s6_async_busy", sif.busy, 0);
    check_eq("s6_async_sweep", sif.sweep_updates, 0);
    tick();
    tick();
    @(negedge clk);
    rst_global = 1'b0;
    check_eq("s6_no_iter_pulse", pulses, 0);
    pulse_start();
    check_eq("s6_restart_node0", sif.node_index, 0);
    roll(1);
    check_eq("s6_restart_node1", sif.node_index, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
